// File: rtl/reset_seq_pkg.sv
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and constants for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reset_seq_pkg;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_EXT  = 2'b01,
        CAUSE_SW   = 2'b10,
        CAUSE_WDOG = 2'b11
    } rst_cause_e;

    typedef enum logic [0:0] {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    localparam logic [7:0] RST_COUNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == RST_COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rst_debounce.sv
// ============================================================================
// Module      : rst_debounce
// Description : Synchronizer plus saturating low-level debounce counter for an
//               asynchronous active-low reset button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_n,
    output logic ext_active
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_n};
        cnt_d  = cnt_q;
        if (sync_q[SYNC_STAGES-1]) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    // Only a full run of synced-low samples counts as a press.
    assign ext_active = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module      : reset_sequencer
// Description : Merges POR, debounced button and software reset requests into
//               one stretched active-low reset; records cause and count.
//               Optional watchdog trigger enabled by macro RST_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int WDOG_CYCLES     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ext_rst_req_n,
    input  logic       sw_rst_req,
    input  logic       wdog_kick,
    output logic       rst_out_n,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] por_sync_q, por_sync_d;
    logic                   por_released;
    logic                   ext_active;
    logic                   wdog_to;

    seq_state_e             state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                   rst_out_n_q, rst_out_n_d;
    rst_cause_e             cause_q, cause_d;
    logic [7:0]             count_q, count_d;

    assign por_sync_d   = {por_sync_q[SYNC_STAGES-2:0], 1'b1};
    assign por_released = por_sync_q[SYNC_STAGES-1];

    rst_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_n      (ext_rst_req_n),
        .ext_active (ext_active)
    );

`ifdef RST_WDOG_EN
    localparam int               WDOG_W    = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

    assign wdog_to = (wdog_cnt_q == WDOG_LAST) && !wdog_kick;

    // Counts only while staying in RUN; any HOLD entry or HOLD cycle clears it.
    always_comb begin
        wdog_cnt_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (wdog_kick) begin
                wdog_cnt_d = '0;
            end else if (wdog_cnt_q != WDOG_LAST) begin
                wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            end else begin
                wdog_cnt_d = wdog_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    logic unused_wdog_kick;
    assign unused_wdog_kick = wdog_kick;
    assign wdog_to          = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cause_d    = cause_q;
        count_d    = count_q;
        case (state_q)
            ST_HOLD: begin
                // A held button keeps restarting the stretch from zero.
                if (!por_released || ext_active) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (ext_active || wdog_to || sw_rst_req) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    count_d    = sat_inc8(count_q);
                    if (ext_active) begin
                        cause_d = CAUSE_EXT;
                    end else if (wdog_to) begin
                        cause_d = CAUSE_WDOG;
                    end else begin
                        cause_d = CAUSE_SW;
                    end
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign rst_out_n_d = (state_d == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            por_sync_q  <= '0;
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            rst_out_n_q <= 1'b0;
            cause_q     <= CAUSE_POR;
            count_q     <= '0;
        end else begin
            por_sync_q  <= por_sync_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            rst_out_n_q <= rst_out_n_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign rst_cause = cause_q;
    assign rst_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Directed-random bench; expected reset windows are derived from
//               the documented latencies with plain edge arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int WDOG = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ext_n = 1'b1;
    logic       sw = 1'b0;
    logic       kick = 1'b1;
    logic       rst_out_n;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    reset_sequencer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .WDOG_CYCLES     (WDOG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ext_rst_req_n (ext_n),
        .sw_rst_req    (sw),
        .wdog_kick     (kick),
        .rst_out_n     (rst_out_n),
        .rst_cause     (rst_cause),
        .rst_count     (rst_count)
    );

    always #5 clk = ~clk;

    // Model: reset output is low on edges in [fall_at, rise_at); cause and
    // count switch from cur_* to nxt_* at fall_at.
    int         now = 0;
    int         fall_at = 0;
    int         rise_at = 1 << 30;
    logic [1:0] cur_cause = 2'b00;
    logic [1:0] nxt_cause = 2'b00;
    int         cur_cnt = 0;
    int         nxt_cnt = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         len, p0, k;

    task automatic check(input string tag);
        logic       e_out;
        logic [1:0] e_cause;
        int         e_cnt;
        e_out   = !(now >= fall_at && now < rise_at);
        e_cause = (now >= fall_at) ? nxt_cause : cur_cause;
        e_cnt   = (now >= fall_at) ? nxt_cnt : cur_cnt;
        n_assert++;
        assert (rst_out_n === e_out) else begin
            n_fail++;
            $error("FAIL %s.rst_out_n edge=%0d observed=%b expected=%b", tag, now, rst_out_n, e_out);
        end
        n_assert++;
        assert (rst_cause === e_cause) else begin
            n_fail++;
            $error("FAIL %s.rst_cause edge=%0d observed=%b expected=%b", tag, now, rst_cause, e_cause);
        end
        n_assert++;
        assert (rst_count === 8'(e_cnt)) else begin
            n_fail++;
            $error("FAIL %s.rst_count edge=%0d observed=%0d expected=%0d", tag, now, rst_count, e_cnt);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        now++;
        #1;
        check(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic arm(input int f, input int r, input logic [1:0] c);
        cur_cause = nxt_cause;
        cur_cnt   = nxt_cnt;
        nxt_cause = c;
        nxt_cnt   = (cur_cnt < 255) ? cur_cnt + 1 : 255;
        fall_at   = f;
        rise_at   = r;
    endtask

    task automatic por_assert();
        rst_n     = 1'b0;
        cur_cause = 2'b00;
        nxt_cause = 2'b00;
        cur_cnt   = 0;
        nxt_cnt   = 0;
        fall_at   = now;
        rise_at   = 1 << 30;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached at edge %0d", now);
        $fatal(1, "bench timeout");
    end

    initial begin
        // Power-on reset
        #2;
        por_assert();
        #1 check("por_async");
        steps(5, "por_low");
        rst_n   = 1'b1;
        rise_at = now + SYNC + HOLD;
        steps(SYNC + HOLD + 4, "por_release");

        // Short bounces must be filtered out
        repeat (6) begin
            len   = int'($urandom_range(1, DEB - 1));
            ext_n = 1'b0;
            steps(len, "bounce");
            ext_n = 1'b1;
            steps(len + SYNC + 6 + int'($urandom_range(0, 5)), "bounce_idle");
        end

        // Real button presses
        repeat (4) begin
            len = int'($urandom_range(DEB, 12));
            p0  = now;
            arm(p0 + SYNC + DEB + 1, p0 + len + SYNC + 1 + HOLD, 2'b01);
            ext_n = 1'b0;
            steps(len, "ext_press");
            ext_n = 1'b1;
            steps(SYNC + 1 + HOLD + 3 + int'($urandom_range(0, 4)), "ext_release");
        end

        // Software reset, with a second request ignored during HOLD
        repeat (4) begin
            p0 = now;
            arm(p0 + 1, p0 + 1 + HOLD, 2'b10);
            sw = 1'b1;
            step("sw_pulse");
            sw = 1'b0;
            k = int'($urandom_range(1, HOLD - 2));
            steps(k, "sw_hold");
            sw = 1'b1;
            step("sw_in_hold");
            sw = 1'b0;
            steps(HOLD - k + 2 + int'($urandom_range(0, 3)), "sw_release");
        end

        // EXT wins over a coincident SW request
        repeat (2) begin
            len = int'($urandom_range(DEB + SYNC + 2, 12));
            p0  = now;
            arm(p0 + SYNC + DEB + 1, p0 + len + SYNC + 1 + HOLD, 2'b01);
            ext_n = 1'b0;
            steps(SYNC + DEB, "prio_press");
            sw = 1'b1;
            step("prio_trigger");
            sw = 1'b0;
            steps(len - SYNC - DEB - 1, "prio_hold");
            ext_n = 1'b1;
            steps(SYNC + 1 + HOLD + 3, "prio_release");
        end

        // POR in the middle of a SW stretch (hold counter at 7)
        p0 = now;
        arm(p0 + 1, p0 + 1 + HOLD, 2'b10);
        sw = 1'b1;
        step("mid_sw");
        sw = 1'b0;
        steps(7, "mid_hold");
        por_assert();
        #1 check("mid_por_async");
        steps(3, "mid_por_low");
        rst_n   = 1'b1;
        rise_at = now + SYNC + HOLD;
        steps(SYNC + HOLD + 3, "mid_por_release");

`ifdef RST_WDOG_EN
        // Regular kicks keep the watchdog quiet; then let it expire
        kick = 1'b0;
        repeat (5) begin
            steps(39, "wdog_kicked");
            kick = 1'b1;
            step("wdog_kick");
            kick = 1'b0;
        end
        arm(now + WDOG, now + WDOG + HOLD, 2'b11);
        steps(WDOG + HOLD + 3, "wdog_timeout");
        kick = 1'b1;
        steps(2, "wdog_resume");
`endif

        // Count saturation
        repeat (256) begin
            p0 = now;
            arm(p0 + 1, p0 + 1 + HOLD, 2'b10);
            sw = 1'b1;
            step("sat_sw");
            sw = 1'b0;
            steps(HOLD + 1 + int'($urandom_range(0, 2)), "sat_release");
        end
        steps(3, "sat_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Upstream reset-generation stage for the counter/datapath blocks.
- Takes board power-on reset, a bouncy external reset button and a software reset request. Produces one clean, stretched, active-low reset (rst_out_n) that drives the downstream blocks' rst_n.
- Also reports the cause of the last reset and counts non-power-on resets.

Parameters:
- SYNC_STAGES, 2: flops in each synchronizer (rst_n release and ext_rst_req_n); legal 2..4.
- DEBOUNCE_CYCLES, 4: consecutive synced-low cycles before ext_rst_req_n counts as a request; legal 1..255.
- HOLD_CYCLES, 16: cycles rst_out_n stays low after the trigger is released; legal 1..65535.
- WDOG_CYCLES, 1000: watchdog timeout in cycles (RST_WDOG_EN only); legal 2..2^20.

Ports:
- clk, input, 1: single clock domain.
- rst_n, input, 1: power-on reset; asynchronous, active-low.
- ext_rst_req_n, input, 1: external reset button; asynchronous to clk, active-low, may bounce.
- sw_rst_req, input, 1: synchronous single-cycle software reset request.
- wdog_kick, input, 1: synchronous watchdog refresh pulse (ignored without RST_WDOG_EN).
- rst_out_n, output, 1: sequenced reset to downstream; registered, active-low.
- rst_cause, output, 2: 00 POR, 01 EXT, 10 SW, 11 WDOG.
- rst_count, output, 8: saturating count of non-POR resets since last POR.

Behaviour:
- rst_n low (asynchronous) forces all state immediately:
  - state=HOLD, hold_cnt=0, rst_out_n=0, rst_cause=00, rst_count=0.
  - Synchronizer flops=0, debounce counter=0, watchdog counter=0.
- rst_n release:
  - Deassertion passes through a SYNC_STAGES synchronizer (shift of 1s). HOLD does not count until the synced release is 1.
  - rst_out_n rises on clk edge number SYNC_STAGES+HOLD_CYCLES after the first edge that samples rst_n=1 (default 18).
- FSM has two states:
  - HOLD: hold_cnt increments each cycle. When hold_cnt==HOLD_CYCLES-1 and no restart condition, next state is RUN and rst_out_n<=1 on that edge.
  - RUN: rst_out_n=1. Any trigger moves to HOLD on the next edge with rst_out_n<=0, hold_cnt<=0, rst_cause<=trigger cause, and rst_count incremented (saturating at 255).
- Triggers in RUN, priority EXT > WDOG > SW when simultaneous:
  - ext_active: debounce counter == DEBOUNCE_CYCLES.
  - Watchdog timeout.
  - sw_rst_req==1.
- Debounce:
  - ext_rst_req_n passes through a SYNC_STAGES synchronizer.
  - Counter increments on synced 0, saturating at DEBOUNCE_CYCLES, and clears to 0 on synced 1.
  - ext_active is true only at saturation, so a bounce shorter than DEBOUNCE_CYCLES never triggers.
- Restart in HOLD:
  - While ext_active=1, hold_cnt is held at 0. The HOLD_CYCLES stretch begins after the button is released and debounce clears.
  - rst_cause is unchanged on restart; rst_count does not increment again.
  - sw_rst_req and watchdog are ignored in HOLD.
- Widths:
  - hold_cnt is $clog2(HOLD_CYCLES) bits.
  - The debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits.
  - No wrap-around is permitted; counters stop at their terminal value.
- Reset mid-sequence: rst_n low during HOLD or RUN aborts everything; cause becomes 00.

Optional Feature:
- Macro RST_WDOG_EN.
- When defined:
  - A watchdog counter of $clog2(WDOG_CYCLES) bits runs only in RUN.
  - wdog_kick==1 clears it to 0.
  - When it reaches WDOG_CYCLES-1 without a kick on that cycle, a WDOG trigger fires.
  - The counter is cleared on entry to HOLD.
- When undefined: no watchdog logic; wdog_kick is unconnected internally; rst_cause never equals 11.

Decomposition:
- Package reset_seq_pkg holds:
  - rst_cause_e (CAUSE_POR=2'b00, CAUSE_EXT=2'b01, CAUSE_SW=2'b10, CAUSE_WDOG=2'b11).
  - seq_state_e (ST_HOLD, ST_RUN).
  - RST_COUNT_MAX=8'd255.
- One sub-module, rst_debounce: a SYNC_STAGES synchronizer plus a saturating debounce counter that outputs ext_active. It is instantiated once.
- The rst_n release synchronizer stays inline.

Test Plan:
- POR: rst_n low 5 cycles then high, defaults → rst_out_n=0, rst_cause=00 until the 18th edge after release, then rst_out_n=1; rst_count=0.
- Bounce filter: in RUN, ext_rst_req_n low 3 cycles then high → no reset. Then low 10 cycles → rst_out_n falls once ext_active asserts (4 synced-low cycles), rst_cause=01, rst_count=1. rst_out_n rises 16 cycles after ext_active drops.
- SW reset: single sw_rst_req pulse in RUN → rst_out_n=0 next edge, rst_cause=10, rst_out_n=1 after 16 cycles. A second sw_rst_req during HOLD has no effect; rst_count increments by 1 only.
- Priority: ext_active and sw_rst_req in the same RUN cycle → rst_cause=01, rst_count+1.
- Mid-sequence POR: rst_n low at hold_cnt=7 after a SW reset → rst_out_n stays 0, rst_cause=00, rst_count=0; full 18-cycle sequence restarts after release.
- RST_WDOG_EN, WDOG_CYCLES=50: kick every 40 cycles → no reset. Stop kicking → reset 50 cycles after last kick, rst_cause=11. Also drive 256 SW resets → rst_count saturates at 255.
